// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that picks one of four requesters
// and registers its word into a valid/ready output stage, acking each capture.
module rr_mux_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          sel,
  output logic [3:0]          gnt,
  output logic [3:0]          ack,
  output logic                busy
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_next;
  logic [1:0] r_ptr, r_sel, w_base, w_win;
  logic [3:0] r_ack, w_eff;
  logic [DATA_W-1:0] r_data;
  logic w_found, w_cap, w_retire;
  always_comb begin
    w_retire = (r_state == HOLD) && out_ready;
    // a retiring winner moves the search start past itself in the same cycle
    w_base = w_retire ? r_sel + 2'd1 : r_ptr;
    w_eff = req & ~r_ack;
    w_found = 1'b0;
    w_win = w_base;
    for (int k = 3; k >= 0; k--) begin
      if (w_eff[w_base + 2'(k)]) begin
        w_found = 1'b1;
        w_win = w_base + 2'(k);
      end
    end
    w_cap = w_found && ((r_state == IDLE) || out_ready);
    w_next = w_cap ? HOLD : (w_retire ? IDLE : r_state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_sel  <= '0;
      r_ack  <= '0;
      r_data <= '0;
    end else begin
      r_ack <= w_cap ? 4'b0001 << w_win : 4'b0000;
      if (w_cap) begin
        r_data <= data_in[w_win*DATA_W +: DATA_W];
        r_sel  <= w_win;
      end
      if (w_retire) r_ptr <= r_sel + 2'd1;
    end
  end
  assign out_valid = (r_state == HOLD);
  assign busy      = out_valid;
  assign gnt       = out_valid ? 4'b0001 << r_sel : 4'b0000;
  assign ack       = r_ack;
  assign sel       = r_sel;
  assign out_data  = r_data;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, busy;
  logic [7:0]  out_data;
  logic [1:0]  sel;
  logic [3:0]  gnt, ack;
  int passed = 0;
  int total = 0;

  rr_mux_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .sel(sel), .gnt(gnt), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic [3:0] g, input logic [3:0] a);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".busy"},  32'(busy),      32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(sel),       32'(s));
    chk({tag, ".gnt"},   32'(gnt),       32'(g));
    chk({tag, ".ack"},   32'(ack),       32'(a));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    step(); step();
    chk_out("reset", 0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step();
    chk_out("idle_noreq", 0, 8'h00, 2'd0, 4'b0000, 4'b0000);
    req = 4'b0100; data_in[16 +: 8] = 8'hA5;
    step();
    chk_out("cap_a5", 1, 8'hA5, 2'd2, 4'b0100, 4'b0100);
    req = 4'b0000;
    step();
    chk_out("hold_a5", 1, 8'hA5, 2'd2, 4'b0100, 4'b0000);
    async_reset();
    req = 4'b0100;
    step();
    chk_out("cap_a5_again", 1, 8'hA5, 2'd2, 4'b0100, 4'b0100);
    req = 4'b0000; out_ready = 1'b1;
    step();
    chk_out("retire_a5", 0, 8'hA5, 2'd2, 4'b0000, 4'b0000);
    async_reset();
    // round robin from ptr=0 with all four requesters active
    req = 4'b1111; data_in = {8'h43, 8'h32, 8'h21, 8'h10};
    step(); chk_out("rr0", 1, 8'h10, 2'd0, 4'b0001, 4'b0001);
    step(); chk_out("rr1", 1, 8'h21, 2'd1, 4'b0010, 4'b0010);
    step(); chk_out("rr2", 1, 8'h32, 2'd2, 4'b0100, 4'b0100);
    step(); chk_out("rr3", 1, 8'h43, 2'd3, 4'b1000, 4'b1000);
    step(); chk_out("rr4", 1, 8'h10, 2'd0, 4'b0001, 4'b0001);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("backpressure", 1, 8'h10, 2'd0, 4'b0001, 4'b0000);
    end
    out_ready = 1'b1;
    step(); chk_out("bp_release", 1, 8'h21, 2'd1, 4'b0010, 4'b0010);
    // retiring 1 sets ptr=2; search 2,3,0,1 with only 0 and 1 requesting
    req = 4'b0011; data_in[8 +: 8] = 8'h66;
    step(); chk_out("ptr_r0", 1, 8'h10, 2'd0, 4'b0001, 4'b0001);
    step(); chk_out("ptr_r1", 1, 8'h66, 2'd1, 4'b0010, 4'b0010);
    req = 4'b0100; data_in[16 +: 8] = 8'hB0;
    step(); chk_out("single_b0", 1, 8'hB0, 2'd2, 4'b0100, 4'b0100);
    data_in[16 +: 8] = 8'hB1;
    step(); chk_out("single_ackcyc", 0, 8'hB0, 2'd2, 4'b0000, 4'b0000);
    step(); chk_out("single_b1", 1, 8'hB1, 2'd2, 4'b0100, 4'b0100);
    data_in[16 +: 8] = 8'hB2;
    step(); chk_out("single_ackcyc2", 0, 8'hB1, 2'd2, 4'b0000, 4'b0000);
    step(); chk_out("single_b2", 1, 8'hB2, 2'd2, 4'b0100, 4'b0100);
    req = 4'b0000;
    step(); chk_out("idle_return", 0, 8'hB2, 2'd2, 4'b0000, 4'b0000);
    step(); chk_out("idle_stay", 0, 8'hB2, 2'd2, 4'b0000, 4'b0000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and controller for the 4:1 multiplexer datapath. Four requesters share one output channel. The block picks a winner fairly, drives the mux select, and registers the selected word into a valid/ready output stage. It acknowledges each requester once its word has been captured. It sits in front of any single-consumer resource that the team currently feeds through a bare 4:1 mux with a hand-driven select.

## Interface
- DATA_W, default 8: width of each requester's data word and of out_data.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  req[i] high means requester i presents a valid word on its data_in slice.
- data_in  input  4*DATA_W  concatenated words; requester i occupies bits [i*DATA_W +: DATA_W].
- out_ready  input  1  consumer can accept out_data this cycle.
- out_valid  output  1  out_data holds a captured word.
- out_data  output  DATA_W  registered word from the current winner.
- sel  output  2  mux select; this is the index of the current or last winner.
- gnt  output  4  one-hot current owner; all zeros when no word is held.
- ack  output  4  one-cycle pulse on bit i in the cycle after requester i's word is captured.
- busy  output  1  equals out_valid; provided for status monitoring.

## Operation
- State machine with two states: IDLE and HOLD.
- Internal priority pointer ptr[1:0] sets the search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Effective request: eff[i] = req[i] & ~ack[i]. A requester is never re-granted in the cycle its ack is high, so a stale word is never captured.
- Arbitration: the winner w is the first i in search order with eff[i]=1. If no bit is set, there is no winner.
- IDLE with a winner: capture data_in slice w into out_data. Set sel=w, gnt=1<<w, out_valid=1, ack=1<<w, then go to HOLD. With no winner, stay in IDLE with outputs unchanged and gnt=0.
- HOLD with out_ready=0: hold out_data, sel, gnt and out_valid stable. ack returns to 0. Late requests have no effect.
- HOLD with out_ready=1 (handshake):
  - Set ptr = w+1 mod 4, using the winner being retired.
  - Re-arbitrate in the same cycle using the updated ptr. If there is a new winner, capture it, pulse its ack and stay in HOLD, so out_valid stays 1.
  - If there is no new winner, set out_valid=0 and gnt=0, keep sel at its last value, and go to IDLE.
- ack is registered, and at most one bit is high in any cycle.
- out_data is updated only on a capture. It holds its value after the handshake while out_valid=0.

## Timing
- Reset (async assert, any time) sets: state=IDLE, ptr=0, out_valid=0, busy=0, gnt=0, ack=0, sel=0, out_data=0. Reset mid-transfer discards the held word without an ack.
- Latency: a request sampled at edge k in IDLE gives out_valid, gnt, sel, out_data and ack all valid after edge k.
- Throughput: with out_ready held at 1 and requests pending, there is one transfer per clock with no bubble.
- Handshake rule: a transfer occurs at an edge where out_valid=1 and out_ready=1.
- Requester rule: after seeing ack[i], requester i drops req[i] or presents its next word by the following edge.
- Fairness: with all four requesters continuously active, the grant order is 0,1,2,3,0,… and no requester waits more than 3 transfers.
- ptr wrap: when w=3, ptr becomes 0.
- A simultaneous new req[i] rising and handshake is handled by the same-cycle re-arbitration above.

## Test plan
- Reset: drive rst_n=0 mid-HOLD with out_valid=1 -> all outputs go to zero immediately (asynchronous). After release, req=4'b0100 with data 8'hA5 -> out_data=8'hA5, sel=2, gnt=4'b0100, ack=4'b0100 one edge later.
- Round-robin: set req=4'b1111 with data slices 8'h10/8'h21/8'h32/8'h43, and out_ready=1, requesters holding req -> out_data sequence 10,21,32,43,10 on consecutive cycles, with ack rotating 0001,0010,0100,1000,0001.
- Backpressure: with out_ready=0 for 5 cycles while holding a winner -> out_data, sel and gnt stay stable and ack pulses exactly once. Raise out_ready -> transfer occurs and the next winner follows without a bubble.
- Pointer order: after retiring requester 1 (ptr=2), set req=4'b0011 -> requester 0 wins (search order 2,3,0,1), then requester 1.
- Single requester with back-to-back words: hold req[2]=1 with out_ready=1 and change the data word after each ack -> each word is captured exactly once, with no duplicate capture in ack cycles.
- Idle return: after the last handshake, set req=0 -> out_valid=0 and gnt=0, while sel and out_data keep their last values.
